demux_code_reg_bank: RTL
========================

Name: demux_code_reg_bank

Overview:
- Receiving end of the 4-bit register-code path.
- Takes the code produced by the code mux (Code_Dmux) plus a data byte under a four-phase req/ack handshake, decodes the code, and writes the byte into one register of a bank (RTC time/date/timer fields).
- Provides a registered read-back port and per-register "written" flags for the display and control logic.

Parameters:
- NREG, 9, number of implemented registers; valid codes 0..NREG-1, max 16.
- DW, 8, data width of each register.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- Code_Dmux  input  4  destination register code for a write
- Data_In  input  DW  write data
- Wr_Req  input  1  write request, four-phase handshake
- Wr_Ack  output  1  write acknowledge
- Wr_Err  output  1  one-cycle pulse: requested code >= NREG, write discarded
- Rd_Code  input  4  read-back register code
- Data_Out  output  DW  registered read data
- Reg_Valid  output  NREG  bit i set once register i has been written since reset

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high.
- Reset values:
  - all bank registers 0; Data_Out 0; Wr_Ack 0; Wr_Err 0; Reg_Valid all 0; FSM in IDLE.
  - Reset asserted mid-handshake aborts any pending write; the bank is cleared regardless.
- FSM states: IDLE, WRITE, ACK.
  - IDLE: when Wr_Req=1, capture Code_Dmux/Data_In into holding registers; go to WRITE. Otherwise stay.
  - WRITE (one cycle):
    - If held code < NREG: write held data to bank[code], set Reg_Valid[code], drive Wr_Ack=1 from the next edge.
    - If held code >= NREG: no bank change; Wr_Err=1 for exactly one cycle; Wr_Ack=1 anyway so the initiator completes the handshake.
    - Go to ACK.
  - ACK: hold Wr_Ack=1 while Wr_Req=1. When Wr_Req=0 is sampled, Wr_Ack returns to 0 at the next edge; go to IDLE.
- Handshake timing: with Wr_Req first sampled high at edge t:
  - holding registers load at t;
  - bank write occurs at t+1;
  - Wr_Ack is first high after t+2;
  - bank[code] is readable from t+1 onward.
- Input stability: Code_Dmux and Data_In are sampled only at the IDLE->WRITE edge. Later changes are ignored until the next request.
- A new request is accepted only in IDLE. Wr_Req staying high after ACK does not re-trigger; it must drop first.
- Read port:
  - Data_Out <= bank[Rd_Code] on every edge (1-cycle latency); returns 0 if Rd_Code >= NREG.
  - A read and a write to the same register at the same edge return the old value; the new value appears one cycle later.
- Overwrites: rewriting a register overwrites it; Reg_Valid stays set. Reg_Valid clears only on reset.
- Width rules: no arithmetic; DW bits stored verbatim. Codes are compared unsigned against NREG.

Decomposition:
- Shared package (rtc_code_pkg):
  - CODE_W=4;
  - register code constants: CODE_SEG=0, CODE_MIN=1, CODE_HOR=2, CODE_DIA=3, CODE_MES=4, CODE_ANO=5, CODE_TSEG=6, CODE_TMIN=7, CODE_THOR=8;
  - FSM state encoding;
  - NREG default.
- One sub-module is natural: code_decoder_onehot, 4-bit code + enable -> 16-bit one-hot write-enable vector. The bank uses the low NREG bits, and the error path uses "any bit >= NREG set".

Test Plan:
- Reset then idle: release reset; 5 cycles no Wr_Req -> Wr_Ack=0, Wr_Err=0, Reg_Valid=9'h000, Data_Out=0 for Rd_Code=0..15.
- Basic write: Code_Dmux=4'd2, Data_In=8'h23, Wr_Req high at edge t -> Wr_Ack high after t+2; Rd_Code=2 gives Data_Out=8'h23; Reg_Valid=9'h004. Drop Wr_Req -> Wr_Ack=0 one cycle later.
- Invalid code: Code_Dmux=4'd12, Data_In=8'hFF -> Wr_Err single-cycle pulse, Wr_Ack still asserted, bank and Reg_Valid unchanged; Rd_Code=12 gives 0.
- Held request / data change: keep Wr_Req high 10 cycles after ack while changing Data_In to 8'h55 -> exactly one write (8'h23 retained), no second ack. A fresh request after Wr_Req drops writes 8'h55.
- Read-during-write: Rd_Code=5 held while writing Code_Dmux=5, Data_In=8'h16 -> Data_Out shows old value 8'h00 on the write edge, 8'h16 on the next.
- Reset mid-operation: assert reset while in ACK with bank[2]=8'h23 -> next edge Wr_Ack=0, bank cleared, Reg_Valid=0. After reset release with Wr_Req still high, the write is accepted as a new request.

Source files
------------

// File: rtl/demux_code_reg_bank_pkg.sv
// Shared definitions for the RTC register-code path:
// code width, register codes, bank size and write FSM states.
package rtc_code_pkg;

   localparam int CODE_W   = 4;
   localparam int NCODE    = 1 << CODE_W;
   localparam int NREG_DEF = 9;
   localparam int DW_DEF   = 8;

   localparam logic [CODE_W-1:0] CODE_SEG  = 4'd0;
   localparam logic [CODE_W-1:0] CODE_MIN  = 4'd1;
   localparam logic [CODE_W-1:0] CODE_HOR  = 4'd2;
   localparam logic [CODE_W-1:0] CODE_DIA  = 4'd3;
   localparam logic [CODE_W-1:0] CODE_MES  = 4'd4;
   localparam logic [CODE_W-1:0] CODE_ANO  = 4'd5;
   localparam logic [CODE_W-1:0] CODE_TSEG = 4'd6;
   localparam logic [CODE_W-1:0] CODE_TMIN = 4'd7;
   localparam logic [CODE_W-1:0] CODE_THOR = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_ACK   = 2'd2
   } wr_state_e;

endpackage

// File: rtl/demux_code_reg_bank_decoder.sv
// One-hot write-enable decoder: 4-bit register code
// plus enable to a 16-bit one-hot vector.
module code_decoder_onehot
   import rtc_code_pkg::*;
(
   input  logic [CODE_W-1:0] code_i,
   input  logic              en_i,
   output logic [NCODE-1:0]  onehot_o
);

   // Exactly one bit set when enabled, none otherwise
   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[code_i] = 1'b1;
      end
   end

endmodule

// File: rtl/demux_code_reg_bank.sv
// Register bank fed by the code mux under a four-phase
// req/ack handshake, with registered read-back port.
module demux_code_reg_bank
   import rtc_code_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int DW   = DW_DEF
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [CODE_W-1:0] Code_Dmux,
   input  logic [DW-1:0]     Data_In,
   input  logic              Wr_Req,
   output logic              Wr_Ack,
   output logic              Wr_Err,
   input  logic [CODE_W-1:0] Rd_Code,
   output logic [DW-1:0]     Data_Out,
   output logic [NREG-1:0]   Reg_Valid
);

   // Codes at or above NREG fall outside this mask
   localparam logic [NCODE-1:0] VALID_MASK =
      (NREG >= NCODE) ? '1 : NCODE'((1 << NREG) - 1);

   wr_state_e         state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [DW-1:0]     data_q, data_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [DW-1:0]     dout_q, dout_d;
   logic [DW-1:0]     bank_q [NREG];
   logic [NREG-1:0]   valid_q;
   logic [NCODE-1:0]  onehot;
   logic [NREG-1:0]   we;
   logic              wr_bad;

   code_decoder_onehot u_dec (
      .code_i   (code_q),
      .en_i     (state_q == ST_WRITE),
      .onehot_o (onehot)
   );

   assign we     = onehot[NREG-1:0];
   assign wr_bad = |(onehot & ~VALID_MASK);

   // Handshake FSM: capture in IDLE, commit in WRITE, hold ack
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      data_d  = data_q;
      ack_d   = ack_q;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            ack_d = 1'b0;
            if (Wr_Req) begin
               code_d  = Code_Dmux;
               data_d  = Data_In;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            err_d   = wr_bad;
            state_d = ST_ACK;
         end
         ST_ACK: begin
            ack_d = Wr_Req;
            if (!Wr_Req) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ack_d   = 1'b0;
         end
      endcase
   end

   // Control, holding and status registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         code_q  <= '0;
         data_q  <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Bank storage and sticky written flags
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            bank_q[i] <= '0;
         end
         valid_q <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (we[i]) begin
               bank_q[i]  <= data_q;
               valid_q[i] <= 1'b1;
            end
         end
      end
   end

   // Read mux; unimplemented codes read as zero
   always_comb begin
      dout_d = '0;
      for (int i = 0; i < NREG; i++) begin
         if (Rd_Code == CODE_W'(i)) begin
            dout_d = bank_q[i];
         end
      end
   end

   // Registered read data, one cycle behind Rd_Code
   always_ff @(posedge clk) begin
      if (reset) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign Wr_Ack    = ack_q;
   assign Wr_Err    = err_q;
   assign Data_Out  = dout_q;
   assign Reg_Valid = valid_q;

endmodule
